// File: rtl/baseerat_pkg.sv
// Shared constants for the baseerat demux: section slice width and the
// encoding of the destination select.
package baseerat_pkg;

  // Routing granularity; every section of a word follows the same select.
  localparam int unsigned SECTION_WIDTH = 16;

  // Destination select encoding: a 1 on sel steers to port 0.
  typedef enum logic {
    PortSel1 = 1'b0,
    PortSel0 = 1'b1
  } port_sel_e;

endpackage

// File: rtl/baseerat_demux_slot.sv
// One output port of the baseerat demux. Holds a word until the downstream
// takes it. Build option: define BASEERAT_DEMUX_SKID_EN for a 2-entry skid
// buffer whose ready is a registered flag; otherwise a single output register
// whose ready looks through to the downstream ready.
module baseerat_demux_slot #(
  parameter int unsigned DATA_WIDTH = 160
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  out_ready_i
);

`ifdef BASEERAT_DEMUX_SKID_EN

  logic                  head_valid_q, head_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  pop;

  assign pop     = head_valid_q & out_ready_i;
  // Full only when the skid entry is occupied; no path from out_ready_i.
  assign ready_o = ~skid_valid_q;
  assign valid_o = head_valid_q;
  assign data_o  = head_q;

  // Pop advances skid into head; push fills head if it is free, else skid.
  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_d       = head_q;
    skid_d       = skid_q;
    if (pop) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        head_valid_d = 1'b0;
      end
    end
    if (push_i) begin
      if (!head_valid_d) begin
        head_valid_d = 1'b1;
        head_d       = data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = data_i;
      end
    end
  end

  // Storage registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
    end
  end

`else

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Accept when empty or when the held word leaves this same cycle.
  assign ready_o = ~valid_q | out_ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // A push overrides the drain so replacement happens without a bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready_i) valid_d = 1'b0;
    if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`endif

endmodule

// File: rtl/baseerat_demux.sv
// 1-to-2 valid/ready demultiplexer: sel=1 steers a word to port 0, sel=0 to
// port 1, one cycle of latency. Each port has independent storage so a stall
// on one never blocks the other. Build option BASEERAT_DEMUX_SKID_EN selects
// per-port 2-entry skid storage (see baseerat_demux_slot).
module baseerat_demux #(
  parameter int unsigned DATA_WIDTH    = 160,
  parameter int unsigned SECTION_WIDTH = baseerat_pkg::SECTION_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  sel,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  dout0_ready,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  input  logic                  dout1_ready
);
  import baseerat_pkg::*;

  localparam int unsigned NumSections = DATA_WIDTH / SECTION_WIDTH;

  if (DATA_WIDTH % SECTION_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of SECTION_WIDTH");
  end

  logic [DATA_WIDTH-1:0] slot_din;
  logic                  ready0, ready1;
  logic                  push0, push1;
  port_sel_e             sel_port;

  assign sel_port = port_sel_e'(sel);

  // Every section is steered by the same select, so all slices land together.
  for (genvar s = 0; s < NumSections; s++) begin : g_sec
    assign slot_din[s*SECTION_WIDTH +: SECTION_WIDTH] = din[s*SECTION_WIDTH +: SECTION_WIDTH];
  end

  // Steer the handshake to the selected slot only.
  always_comb begin
    din_ready = (sel_port == PortSel0) ? ready0 : ready1;
    push0     = din_valid & din_ready & (sel_port == PortSel0);
    push1     = din_valid & din_ready & (sel_port == PortSel1);
  end

  baseerat_demux_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot0 (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .push_i      (push0),
    .data_i      (slot_din),
    .ready_o     (ready0),
    .valid_o     (dout0_valid),
    .data_o      (dout0),
    .out_ready_i (dout0_ready)
  );

  baseerat_demux_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot1 (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .push_i      (push1),
    .data_i      (slot_din),
    .ready_o     (ready1),
    .valid_o     (dout1_valid),
    .data_o      (dout1),
    .out_ready_i (dout1_ready)
  );

endmodule

// File: doc/baseerat_demux.md
BASEERAT_DEMUX -- requirements
Module: baseerat_demux

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 160, the datapath width in bits, a multiple of 16.
REQ-002 The block SHALL have parameter SECTION_WIDTH, default 16, fixed, the slice width used for per-section routing.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 din  input  DATA_WIDTH  input word.
REQ-006 din_valid  input  1  din and sel are valid.
REQ-007 sel  input  1  destination: 1 routes to port 0, 0 routes to port 1.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 dout0 / dout1  output  DATA_WIDTH  output words.
REQ-010 dout0_valid / dout1_valid  output  1  output word valid.
REQ-011 dout0_ready / dout1_ready  input  1  downstream accepts the output word.

Function
REQ-012 Input transfer SHALL occur on a cycle with din_valid=1 and din_ready=1; output k transfer SHALL occur with doutk_valid=1 and doutk_ready=1.
REQ-013 Each accepted word SHALL appear on the selected port one cycle after acceptance (latency 1), with all DATA_WIDTH/16 sections routed identically.
REQ-014 The unselected port SHALL be unaffected by the transfer: its valid and data are held.
REQ-015 Each port SHALL hold valid and data stable until its transfer completes; valid SHALL NOT deassert without a transfer.
REQ-016 Without the skid option, din_ready SHALL equal (~doutk_valid | doutk_ready) for k selected by sel (a combinational path from ready to ready is permitted).
REQ-017 Simultaneous output transfer and new input to the same port SHALL replace the word in the same cycle with no bubble.
REQ-018 A stalled port SHALL NOT block traffic to the other port.
REQ-019 din_valid=0 SHALL leave all state unchanged except output draining.
REQ-020 The block SHALL never drop, duplicate or reorder words per port.

Reset
REQ-021 While resetn=0, dout0_valid and dout1_valid SHALL be 0, dout0 and dout1 SHALL be 0, and all skid storage SHALL be empty, independent of clk.
REQ-022 din_ready SHALL follow REQ-016/REQ-025 using the reset state (1 after reset with empty ports); words in flight at reset assertion SHALL be discarded.
REQ-023 Operation SHALL resume on the first rising edge after resetn deasserts.

Configuration
REQ-024 Macro BASEERAT_DEMUX_SKID_EN SHALL select per-port 2-entry skid buffering.
REQ-025 With BASEERAT_DEMUX_SKID_EN defined, din_ready SHALL equal ~full_k, where full_k is a registered flag of the selected port, with no combinational path from doutk_ready to din_ready. Full throughput SHALL be maintained with 1-cycle latency on an empty port.
REQ-026 Without BASEERAT_DEMUX_SKID_EN, each port SHALL have a single output register and REQ-016 applies.

Structure
REQ-027 SECTION_WIDTH=16 and the port-index encoding (sel=1 maps to port 0) SHALL be defined as constants in shared package baseerat_pkg.
REQ-028 Per-port storage SHALL be a sub-module baseerat_demux_slot, instantiated twice, containing the register or skid logic selected by the macro.

Verification
REQ-029 Reset: hold resetn=0 with din_valid=1 -> both valids 0, douts 0; after release din_ready=1.
REQ-030 Routing: send 0xA5A5 pattern with sel=1, then 0x5A5A with sel=0, both readies=1 -> dout0=0xA5A5 pattern one cycle after the first word, dout1=0x5A5A pattern one cycle after the second word, no cross-talk.
REQ-031 Back-pressure: dout0_ready=0 with 3 words for port 0 -> first word held stable. Without the macro, din_ready=0 after word 1; with the macro, din_ready=0 after word 2. On release, words exit in order.
REQ-032 Isolation: port 0 stalled; 10 words with sel=0 -> all 10 words appear on dout1 at 1 word/cycle.
REQ-033 Throughput: 100 words with alternating sel, readies=1 -> 100 cycles plus 1 latency, zero bubbles, scoreboard match.
REQ-034 Mid-operation reset: assert resetn=0 with both ports valid -> valids 0 asynchronously; no stale word after release.
